// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit and the datapath top:
// state encoding, opcode/funct values, ALU codes and mux select codes.
package mc_pkg;

   typedef enum logic [4:0] {
      ST_FETCH    = 5'd0,
      ST_DECODE   = 5'd1,
      ST_R_EXEC   = 5'd2,
      ST_R_WB     = 5'd3,
      ST_I_EXEC   = 5'd4,
      ST_I_WB     = 5'd5,
      ST_MEM_ADDR = 5'd6,
      ST_MEM_RD   = 5'd7,
      ST_WB_LOAD  = 5'd8,
      ST_MEM_WR   = 5'd9,
      ST_BRANCH   = 5'd10,
      ST_JUMP     = 5'd11,
      ST_EXC      = 5'd12
   } state_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;

   // Ula32 operation codes
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;

   // Mux select codes
   localparam logic       SRCA_PC      = 1'b0;
   localparam logic       SRCA_A       = 1'b1;
   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_EXC    = 2'd3;
   localparam logic [1:0] WREG_RT      = 2'd0;
   localparam logic [1:0] WREG_RD      = 2'd1;
   localparam logic [1:0] WREG_RA      = 2'd2;
   localparam logic [2:0] WDATA_ALUOUT = 3'd0;
   localparam logic [2:0] WDATA_MEM    = 3'd1;

   // Control word emitted each cycle
   typedef struct packed {
      logic       pc_load;
      logic       ir_load;
      logic       mem_write;
      logic       iord_sel;
      logic       reg_write;
      logic [1:0] wreg_sel;
      logic [2:0] wdata_sel;
      logic       a_load;
      logic       b_load;
      logic       aluout_load;
      logic       alusrc_a_sel;
      logic [1:0] alusrc_b_sel;
      logic [2:0] alu_op;
      logic [1:0] pcsrc_sel;
      logic       epc_load;
   } ctl_t;

   // States that perform a memory access and therefore run the wait counter
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_wait_ctr.sv
// Memory access completion tracker: either a fixed number of extra wait
// cycles counted by a 4-bit counter, or the memory's ready handshake.
module mc_wait_ctr
   import mc_pkg::*;
#(
   parameter bit          MEM_HANDSHAKE = 1'b0,
   parameter int unsigned MEM_WAIT      = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic mem_ready,
   output logic done
);

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   logic [3:0] cnt;

   // Completion is only meaningful inside a memory state; ready elsewhere is ignored
   always_comb begin
      done = active & (MEM_HANDSHAKE ? mem_ready : (cnt == WAIT_LAST));
   end

   // Count while an access is pending; any completed or absent access clears it,
   // so the counter is already zero whenever a memory state is entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (active && !done) begin
         // NOTE: non-blocking assignment so every flop samples pre-edge values
         cnt <= cnt + 4'd1;
      end else begin
         cnt <= '0;
      end
   end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle control FSM for the Processador datapath. Decodes IR opcode and
// funct plus ALU flags into register strobes and mux selects.
module mc_ctrl_unit
   import mc_pkg::*;
#(
   parameter bit          MEM_HANDSHAKE = 1'b0,
   parameter int unsigned MEM_WAIT      = 1,
   parameter bit          OVF_TRAP      = 1'b1,
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_00FF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   input  logic        mem_ready,
   output logic        pc_load,
   output logic        ir_load,
   output logic        mem_write,
   output logic        iord_sel,
   output logic        reg_write,
   output logic [1:0]  wreg_sel,
   output logic [2:0]  wdata_sel,
   output logic        a_load,
   output logic        b_load,
   output logic        aluout_load,
   output logic        alusrcA_sel,
   output logic [1:0]  alusrcB_sel,
   output logic [2:0]  alu_op,
   output logic [1:0]  pcsrc_sel,
   output logic        epc_load,
   output logic [31:0] exc_vector,
   output logic [4:0]  state_dbg
);

   state_t state, state_next;
   ctl_t   ctl;
   logic   mem_active, mem_done;
   logic   r_trap, i_trap, branch_taken;

   assign mem_active = is_mem_state(state);

   mc_wait_ctr #(
      .MEM_HANDSHAKE (MEM_HANDSHAKE),
      .MEM_WAIT      (MEM_WAIT)
   ) u_wait_ctr (
      .clk       (clk),
      .rst       (rst),
      .active    (mem_active),
      .mem_ready (mem_ready),
      .done      (mem_done)
   );

   // Overflow only traps on add/sub/addi; 'and' never traps
   assign r_trap       = OVF_TRAP & alu_overflow & (funct != FN_AND);
   assign i_trap       = OVF_TRAP & alu_overflow;
   assign branch_taken = ((opcode == OP_BEQ) & alu_zero) | ((opcode == OP_BNE) & ~alu_zero);

   // State register: async reset aborts any access and returns to fetch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_FETCH;
      else      state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         ST_FETCH:    if (mem_done) state_next = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_RTYPE:      state_next = (funct == FN_ADD || funct == FN_SUB || funct == FN_AND)
                                           ? ST_R_EXEC : ST_EXC;
               OP_ADDI:       state_next = ST_I_EXEC;
               OP_LW, OP_SW:  state_next = ST_MEM_ADDR;
               OP_BEQ, OP_BNE: state_next = ST_BRANCH;
               OP_J:          state_next = ST_JUMP;
               default:       state_next = ST_EXC;
            endcase
         end
         ST_R_EXEC:   state_next = r_trap ? ST_EXC : ST_R_WB;
         ST_I_EXEC:   state_next = i_trap ? ST_EXC : ST_I_WB;
         ST_MEM_ADDR: state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   if (mem_done) state_next = ST_WB_LOAD;
         ST_MEM_WR:   if (mem_done) state_next = ST_FETCH;
         ST_R_WB, ST_I_WB, ST_WB_LOAD, ST_BRANCH, ST_JUMP, ST_EXC:
                      state_next = ST_FETCH;
         default:     state_next = ST_FETCH;
      endcase
   end

   // Output decode from the registered state; held idle while reset is low
   always_comb begin
      // NOTE: every control bit gets a default first, so no path can infer a latch
      ctl        = '0;
      ctl.alu_op = ALU_ADD;
      if (rst) begin
         unique case (state)
            ST_FETCH: begin
               ctl.alusrc_b_sel = SRCB_FOUR;
               if (mem_done) begin
                  ctl.ir_load = 1'b1;
                  ctl.pc_load = 1'b1;
               end
            end
            ST_DECODE: begin
               ctl.a_load       = 1'b1;
               ctl.b_load       = 1'b1;
               ctl.aluout_load  = 1'b1;
               ctl.alusrc_b_sel = SRCB_IMM_SH2;
            end
            ST_R_EXEC: begin
               ctl.alusrc_a_sel = SRCA_A;
               ctl.alusrc_b_sel = SRCB_B;
               ctl.aluout_load  = 1'b1;
               ctl.alu_op       = (funct == FN_SUB) ? ALU_SUB :
                                  (funct == FN_AND) ? ALU_AND : ALU_ADD;
            end
            ST_R_WB: begin
               ctl.reg_write = 1'b1;
               ctl.wreg_sel  = WREG_RD;
               ctl.wdata_sel = WDATA_ALUOUT;
            end
            ST_I_EXEC, ST_MEM_ADDR: begin
               ctl.alusrc_a_sel = SRCA_A;
               ctl.alusrc_b_sel = SRCB_IMM;
               ctl.aluout_load  = 1'b1;
            end
            ST_I_WB: begin
               ctl.reg_write = 1'b1;
               ctl.wreg_sel  = WREG_RT;
               ctl.wdata_sel = WDATA_ALUOUT;
            end
            ST_MEM_RD:  ctl.iord_sel = 1'b1;
            ST_WB_LOAD: begin
               ctl.reg_write = 1'b1;
               ctl.wreg_sel  = WREG_RT;
               ctl.wdata_sel = WDATA_MEM;
            end
            ST_MEM_WR: begin
               ctl.iord_sel  = 1'b1;
               ctl.mem_write = 1'b1;
            end
            ST_BRANCH: begin
               ctl.alusrc_a_sel = SRCA_A;
               ctl.alusrc_b_sel = SRCB_B;
               ctl.alu_op       = ALU_SUB;
               if (branch_taken) begin
                  ctl.pc_load   = 1'b1;
                  ctl.pcsrc_sel = PCSRC_ALUOUT;
               end
            end
            ST_JUMP: begin
               ctl.pc_load   = 1'b1;
               ctl.pcsrc_sel = PCSRC_JUMP;
            end
            ST_EXC: begin
               ctl.epc_load     = 1'b1;
               ctl.alusrc_a_sel = SRCA_PC;
               ctl.alusrc_b_sel = SRCB_FOUR;
               ctl.alu_op       = ALU_SUB;
               ctl.pc_load      = 1'b1;
               ctl.pcsrc_sel    = PCSRC_EXC;
            end
            default: ;
         endcase
      end
   end

   assign pc_load     = ctl.pc_load;
   assign ir_load     = ctl.ir_load;
   assign mem_write   = ctl.mem_write;
   assign iord_sel    = ctl.iord_sel;
   assign reg_write   = ctl.reg_write;
   assign wreg_sel    = ctl.wreg_sel;
   assign wdata_sel   = ctl.wdata_sel;
   assign a_load      = ctl.a_load;
   assign b_load      = ctl.b_load;
   assign aluout_load = ctl.aluout_load;
   assign alusrcA_sel = ctl.alusrc_a_sel;
   assign alusrcB_sel = ctl.alusrc_b_sel;
   assign alu_op      = ctl.alu_op;
   assign pcsrc_sel   = ctl.pcsrc_sel;
   assign epc_load    = ctl.epc_load;
   assign exc_vector  = EXC_VECTOR;
   assign state_dbg   = state;

endmodule
